// File: rtl/id_decode_pipe_if.sv
// id_decode_pipe_if: bundles the fetch, register-file, write-back and
// execute-side signals of the RV32I decode stage.
// The slave modport is the decode stage's view; master is the environment's.
interface id_decode_pipe_if #(
    parameter int XLEN = 32
);
    // Fetch side
    logic             if_valid_i;
    logic [31:0]      if_instr_i;
    logic [XLEN-1:0]  if_pc_i;
    logic             id_ready_o;

    // Register file read port
    logic [4:0]       rf_rs1_addr_o;
    logic [4:0]       rf_rs2_addr_o;
    logic [XLEN-1:0]  rf_rs1_data_i;
    logic [XLEN-1:0]  rf_rs2_data_i;

    // Write-back snoop
    logic             wb_en_i;
    logic [4:0]       wb_addr_i;
    logic [XLEN-1:0]  wb_data_i;

    // Execute side
    logic             ex_ready_i;
    logic             ex_flush_i;
    logic             ex_valid_o;
    logic [XLEN-1:0]  ex_pc_o;
    logic [XLEN-1:0]  ex_rs1_data_o;
    logic [XLEN-1:0]  ex_rs2_data_o;
    logic [XLEN-1:0]  ex_imm_o;
    logic [4:0]       ex_rs1_addr_o;
    logic [4:0]       ex_rs2_addr_o;
    logic [4:0]       ex_rd_addr_o;
    logic [3:0]       ex_funct_o;
    logic             ex_branch_o;
    logic             ex_jump_o;
    logic             ex_memread_o;
    logic             ex_memtoreg_o;
    logic             ex_memwrite_o;
    logic             ex_regwrite_o;
    logic             ex_illegal_o;

    modport slave (
        input  if_valid_i, if_instr_i, if_pc_i,
        output id_ready_o,
        output rf_rs1_addr_o, rf_rs2_addr_o,
        input  rf_rs1_data_i, rf_rs2_data_i,
        input  wb_en_i, wb_addr_i, wb_data_i,
        input  ex_ready_i, ex_flush_i,
        output ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
        output ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_funct_o,
        output ex_branch_o, ex_jump_o, ex_memread_o, ex_memtoreg_o,
        output ex_memwrite_o, ex_regwrite_o, ex_illegal_o
    );

    modport master (
        output if_valid_i, if_instr_i, if_pc_i,
        input  id_ready_o,
        input  rf_rs1_addr_o, rf_rs2_addr_o,
        output rf_rs1_data_i, rf_rs2_data_i,
        output wb_en_i, wb_addr_i, wb_data_i,
        output ex_ready_i, ex_flush_i,
        input  ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
        input  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_funct_o,
        input  ex_branch_o, ex_jump_o, ex_memread_o, ex_memtoreg_o,
        input  ex_memwrite_o, ex_regwrite_o, ex_illegal_o
    );
endinterface

// File: rtl/id_decode_pipe.sv
// id_decode_pipe: pipelined RV32I decode stage. Decodes one fetch word per
// cycle, reads the register file, optionally bypasses same-cycle write-back
// data and registers everything into the ID/EX register with valid/ready
// flow control and branch flush.
// Optional feature macro: ID_LOAD_USE_INTERLOCK_EN enables load-use hazard
// detection with a one-cycle bubble; without it hazard is tied to 0.
module id_decode_pipe #(
    parameter int XLEN      = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    id_decode_pipe_if.slave bus
);

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_IL,
        CLS_S,
        CLS_B,
        CLS_J,
        CLS_JR,
        CLS_U,
        CLS_UPC,
        CLS_ILLEGAL
    } instr_class_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [3:0]      funct;
        logic            branch;
        logic            jump;
        logic            memread;
        logic            memtoreg;
        logic            memwrite;
        logic            regwrite;
        logic            illegal;
    } idex_t;

    logic [31:0]  instr;
    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [4:0]   rs1_idx;
    logic [4:0]   rs2_idx;
    logic [4:0]   rd_idx;
    instr_class_e cls;

    logic         uses_rs1;
    logic         uses_rs2;
    logic         writes_rd;
    logic [3:0]   funct;
    logic [31:0]  imm32;
    logic [31:0]  imm_i;
    logic [31:0]  imm_s;
    logic [31:0]  imm_b;
    logic [31:0]  imm_u;
    logic [31:0]  imm_j;

    logic         bypass_rs1;
    logic         bypass_rs2;
    logic         hazard;
    logic         adv;

    idex_t        dec;
    idex_t        idex_d;
    idex_t        idex_q;

    assign instr   = bus.if_instr_i;
    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign rd_idx  = instr[11:7];
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];

    // The register file is read with the raw index fields every cycle.
    assign bus.rf_rs1_addr_o = rs1_idx;
    assign bus.rf_rs2_addr_o = rs2_idx;

    // Raw RV32I immediate formats, all sign-extended from instr[31].
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // Classify the opcode; anything not in the supported set is illegal.
    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            7'b0110011: cls = CLS_R;
            7'b0010011: cls = CLS_I;
            7'b0000011: cls = CLS_IL;
            7'b0100011: cls = CLS_S;
            7'b1100011: cls = CLS_B;
            7'b1101111: cls = CLS_J;
            7'b1100111: cls = CLS_JR;
            7'b0110111: cls = CLS_U;
            7'b0010111: cls = CLS_UPC;
            default:    cls = CLS_ILLEGAL;
        endcase
    end

    // Per-class register usage, immediate format and funct field.
    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        imm32     = '0;
        funct     = {1'b0, funct3};
        case (cls)
            CLS_R: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
                funct     = {instr[30], funct3};
            end
            CLS_I: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                imm32     = imm_i;
                if (funct3 == 3'b101) begin
                    funct = {instr[30], funct3};
                end
            end
            CLS_IL: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                imm32     = imm_i;
            end
            CLS_S: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                imm32     = imm_s;
            end
            CLS_B: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                imm32     = imm_b;
            end
            CLS_J: begin
                writes_rd = 1'b1;
                imm32     = imm_j;
            end
            CLS_JR: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                imm32     = imm_i;
            end
            CLS_U, CLS_UPC: begin
                writes_rd = 1'b1;
                imm32     = imm_u;
            end
            default: begin
                funct = {1'b0, funct3};
            end
        endcase
    end

    // Write-back data wins over the register file when it targets a used,
    // non-zero source index in the same cycle.
    always_comb begin
        bypass_rs1 = WB_BYPASS && bus.wb_en_i && (bus.wb_addr_i != 5'd0) &&
                     (bus.wb_addr_i == rs1_idx);
        bypass_rs2 = WB_BYPASS && bus.wb_en_i && (bus.wb_addr_i != 5'd0) &&
                     (bus.wb_addr_i == rs2_idx);
    end

    // Assemble the ID/EX entry the current fetch word would produce.
    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.pc       = bus.if_pc_i;
        dec.rs1_addr = uses_rs1 ? rs1_idx : 5'd0;
        dec.rs2_addr = uses_rs2 ? rs2_idx : 5'd0;
        dec.rd_addr  = writes_rd ? rd_idx : 5'd0;
        if (uses_rs1) begin
            dec.rs1_data = bypass_rs1 ? bus.wb_data_i : bus.rf_rs1_data_i;
        end
        if (uses_rs2) begin
            dec.rs2_data = bypass_rs2 ? bus.wb_data_i : bus.rf_rs2_data_i;
        end
        dec.imm      = XLEN'($signed(imm32));
        dec.funct    = funct;
        dec.regwrite = writes_rd && (rd_idx != 5'd0);
        dec.memread  = (cls == CLS_IL);
        dec.memtoreg = (cls == CLS_IL);
        dec.memwrite = (cls == CLS_S);
        dec.branch   = (cls == CLS_B);
        dec.jump     = (cls == CLS_J) || (cls == CLS_JR);
        dec.illegal  = (cls == CLS_ILLEGAL);
    end

`ifdef ID_LOAD_USE_INTERLOCK_EN
    // A load in ID/EX whose destination feeds the fetch word forces a bubble.
    always_comb begin
        hazard = idex_q.valid && idex_q.memread && (idex_q.rd_addr != 5'd0) &&
                 ((uses_rs1 && (idex_q.rd_addr == rs1_idx)) ||
                  (uses_rs2 && (idex_q.rd_addr == rs2_idx)));
    end
`else
    // Without the interlock, software is responsible for load-use spacing.
    always_comb begin
        hazard = 1'b0;
    end
`endif

    assign adv            = !idex_q.valid || bus.ex_ready_i;
    assign bus.id_ready_o = bus.ex_flush_i || (adv && !hazard);

    // Next ID/EX content: flush beats stall beats bubble beats load.
    always_comb begin
        idex_d = idex_q;
        if (bus.ex_flush_i) begin
            idex_d = '0;
        end else if (!adv) begin
            idex_d = idex_q;
        end else if (hazard) begin
            idex_d = '0;
        end else if (bus.if_valid_i) begin
            idex_d = dec;
        end else begin
            idex_d = '0;
        end
    end

    // ID/EX pipeline register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.ex_valid_o    = idex_q.valid;
    assign bus.ex_pc_o       = idex_q.pc;
    assign bus.ex_rs1_data_o = idex_q.rs1_data;
    assign bus.ex_rs2_data_o = idex_q.rs2_data;
    assign bus.ex_imm_o      = idex_q.imm;
    assign bus.ex_rs1_addr_o = idex_q.rs1_addr;
    assign bus.ex_rs2_addr_o = idex_q.rs2_addr;
    assign bus.ex_rd_addr_o  = idex_q.rd_addr;
    assign bus.ex_funct_o    = idex_q.funct;
    assign bus.ex_branch_o   = idex_q.branch;
    assign bus.ex_jump_o     = idex_q.jump;
    assign bus.ex_memread_o  = idex_q.memread;
    assign bus.ex_memtoreg_o = idex_q.memtoreg;
    assign bus.ex_memwrite_o = idex_q.memwrite;
    assign bus.ex_regwrite_o = idex_q.regwrite;
    assign bus.ex_illegal_o  = idex_q.illegal;

endmodule

// File: tb/tb_id_decode_pipe.sv
// tb_id_decode_pipe: directed and randomized stimulus for id_decode_pipe,
// checked against a behavioural RV32I decode model and an ID/EX occupancy
// model. Follows ID_LOAD_USE_INTERLOCK_EN the same way the design does.
module tb_id_decode_pipe;

    localparam int XLEN = 32;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rd;
        logic [3:0]  funct;
        logic        br;
        logic        jmp;
        logic        mr;
        logic        mtr;
        logic        mw;
        logic        rw;
        logic        ill;
    } entry_t;

    typedef struct packed {
        logic        rst_n;
        logic        if_valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        ex_ready;
        logic        flush;
    } stim_t;

    logic   clk = 1'b0;
    logic   rst_n;
    int     vectors = 0;
    int     miscompares = 0;
    entry_t model_q = '0;
    bit     state_known = 1'b0;
    logic   last_ready;

    always #5 clk = ~clk;

    id_decode_pipe_if #(.XLEN(XLEN)) bus ();

    id_decode_pipe #(.XLEN(XLEN), .WB_BYPASS(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference decode computed directly from the ISA rules.
    function automatic entry_t modelDecode(input stim_t s);
        entry_t e;
        logic [6:0] op;
        logic [2:0] f3;
        bit r, i, il, st, b, j, jr, u, upc, legal, use1, use2, wr;
        int sx;
        int imm;
        e  = '0;
        op = s.instr[6:0];
        f3 = s.instr[14:12];
        r  = (op == 7'h33); i  = (op == 7'h13); il = (op == 7'h03);
        st = (op == 7'h23); b  = (op == 7'h63); j  = (op == 7'h6F);
        jr = (op == 7'h67); u  = (op == 7'h37); upc = (op == 7'h17);
        legal = r | i | il | st | b | j | jr | u | upc;
        use1  = r | i | il | st | b | jr;
        use2  = r | st | b;
        wr    = r | i | il | j | jr | u | upc;
        sx    = $signed(s.instr);
        imm   = 0;
        if (i | il | jr) imm = sx >>> 20;
        if (st) imm = ((sx >>> 25) <<< 5) | int'(s.instr[11:7]);
        if (b)  imm = ((sx >>> 31) <<< 12) | (int'(s.instr[7]) << 11) |
                      (int'(s.instr[30:25]) << 5) | (int'(s.instr[11:8]) << 1);
        if (u | upc) imm = int'(s.instr & 32'hFFFF_F000);
        if (j)  imm = ((sx >>> 31) <<< 20) | (int'(s.instr[19:12]) << 12) |
                      (int'(s.instr[20]) << 11) | (int'(s.instr[30:21]) << 1);
        e.valid = 1'b1;
        e.pc    = s.pc;
        e.imm   = imm;
        e.rs1a  = use1 ? s.instr[19:15] : 5'd0;
        e.rs2a  = use2 ? s.instr[24:20] : 5'd0;
        if (use1) e.rs1d = (s.wb_en && s.wb_addr != 0 && s.wb_addr == s.instr[19:15]) ? s.wb_data : s.d1;
        if (use2) e.rs2d = (s.wb_en && s.wb_addr != 0 && s.wb_addr == s.instr[24:20]) ? s.wb_data : s.d2;
        e.rd    = wr ? s.instr[11:7] : 5'd0;
        e.rw    = wr && (s.instr[11:7] != 0);
        e.mr    = il;
        e.mtr   = il;
        e.mw    = st;
        e.br    = b;
        e.jmp   = j | jr;
        e.ill   = !legal;
        e.funct = (r || (i && f3 == 3'b101)) ? {s.instr[30], f3} : {1'b0, f3};
        return e;
    endfunction

    // Compare the ID/EX outputs with the model's current entry.
    task automatic checkEntry();
        checkOutput("ex_valid", bus.ex_valid_o, model_q.valid);
        checkOutput("ex_branch", bus.ex_branch_o, model_q.br);
        checkOutput("ex_jump", bus.ex_jump_o, model_q.jmp);
        checkOutput("ex_memread", bus.ex_memread_o, model_q.mr);
        checkOutput("ex_memtoreg", bus.ex_memtoreg_o, model_q.mtr);
        checkOutput("ex_memwrite", bus.ex_memwrite_o, model_q.mw);
        checkOutput("ex_regwrite", bus.ex_regwrite_o, model_q.rw);
        checkOutput("ex_illegal", bus.ex_illegal_o, model_q.ill);
        if (model_q.valid) begin
            checkOutput("ex_pc", bus.ex_pc_o, model_q.pc);
            checkOutput("ex_rs1_data", bus.ex_rs1_data_o, model_q.rs1d);
            checkOutput("ex_rs2_data", bus.ex_rs2_data_o, model_q.rs2d);
            checkOutput("ex_imm", bus.ex_imm_o, model_q.imm);
            checkOutput("ex_rs1_addr", bus.ex_rs1_addr_o, model_q.rs1a);
            checkOutput("ex_rs2_addr", bus.ex_rs2_addr_o, model_q.rs2a);
            checkOutput("ex_rd_addr", bus.ex_rd_addr_o, model_q.rd);
            checkOutput("ex_funct", bus.ex_funct_o, model_q.funct);
        end
    endtask

    // Drive one cycle, check combinational outputs, clock, check ID/EX.
    task automatic applyStimulus(input stim_t s);
        entry_t d;
        entry_t nxt;
        bit adv, haz, exp_ready;
        rst_n             = s.rst_n;
        bus.if_valid_i    = s.if_valid;
        bus.if_instr_i    = s.instr;
        bus.if_pc_i       = s.pc;
        bus.rf_rs1_data_i = s.d1;
        bus.rf_rs2_data_i = s.d2;
        bus.wb_en_i       = s.wb_en;
        bus.wb_addr_i     = s.wb_addr;
        bus.wb_data_i     = s.wb_data;
        bus.ex_ready_i    = s.ex_ready;
        bus.ex_flush_i    = s.flush;
        #2;
        d   = modelDecode(s);
        adv = !model_q.valid || s.ex_ready;
`ifdef ID_LOAD_USE_INTERLOCK_EN
        haz = model_q.valid && model_q.mr && model_q.rd != 0 &&
              (d.rs1a == model_q.rd || d.rs2a == model_q.rd);
`else
        haz = 1'b0;
`endif
        exp_ready  = s.flush || (adv && !haz);
        last_ready = bus.id_ready_o;
        if (state_known) begin
            checkOutput("id_ready", bus.id_ready_o, exp_ready);
        end
        checkOutput("rf_rs1_addr", bus.rf_rs1_addr_o, s.instr[19:15]);
        checkOutput("rf_rs2_addr", bus.rf_rs2_addr_o, s.instr[24:20]);
        if (!s.rst_n || s.flush)  nxt = '0;
        else if (!adv)            nxt = model_q;
        else if (haz)             nxt = '0;
        else if (s.if_valid)      nxt = d;
        else                      nxt = '0;
        @(posedge clk);
        #1;
        model_q = nxt;
        if (!s.rst_n) state_known = 1'b1;
        if (state_known) checkEntry();
    endtask

    function automatic stim_t mkStim(input logic [31:0] instr, input logic [31:0] pc);
        stim_t s;
        s          = '0;
        s.rst_n    = 1'b1;
        s.if_valid = 1'b1;
        s.instr    = instr;
        s.pc       = pc;
        s.ex_ready = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 10))
            0:  w[6:0] = 7'h33;
            1:  w[6:0] = 7'h13;
            2:  w[6:0] = 7'h03;
            3:  w[6:0] = 7'h03;
            4:  w[6:0] = 7'h23;
            5:  w[6:0] = 7'h63;
            6:  w[6:0] = 7'h6F;
            7:  w[6:0] = 7'h67;
            8:  w[6:0] = 7'h37;
            9:  w[6:0] = 7'h17;
            default: ;
        endcase
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        stim_t s;
        logic [31:0] held_pc;

        // Reset held two cycles with a valid fetch word present.
        s = mkStim(32'h0050_0093, 32'h100);
        s.rst_n = 1'b0;
        applyStimulus(s);
        applyStimulus(s);
        checkOutput("rst_ready", bus.id_ready_o, 1);
        checkOutput("rst_valid", bus.ex_valid_o, 0);
        checkOutput("rst_pc", bus.ex_pc_o, 0);
        checkOutput("rst_imm", bus.ex_imm_o, 0);
        checkOutput("rst_rs1d", bus.ex_rs1_data_o, 0);
        checkOutput("rst_rd", bus.ex_rd_addr_o, 0);
        checkOutput("rst_funct", bus.ex_funct_o, 0);

        // Back-to-back addi / add.
        applyStimulus(mkStim(32'h0050_0093, 32'h200));
        checkOutput("addi_valid", bus.ex_valid_o, 1);
        checkOutput("addi_imm", bus.ex_imm_o, 5);
        checkOutput("addi_funct", bus.ex_funct_o, 0);
        checkOutput("addi_regwrite", bus.ex_regwrite_o, 1);
        s = mkStim(32'h0020_81B3, 32'h204);
        s.d1 = 32'h11; s.d2 = 32'h22;
        applyStimulus(s);
        checkOutput("add_valid", bus.ex_valid_o, 1);
        checkOutput("add_rs1", bus.ex_rs1_addr_o, 1);
        checkOutput("add_rs2", bus.ex_rs2_addr_o, 2);
        checkOutput("add_rd", bus.ex_rd_addr_o, 3);

        // Write-back bypass, then wb_addr 0 which must not bypass.
        s.wb_en = 1'b1; s.wb_addr = 5'd1; s.wb_data = 32'hAA;
        applyStimulus(s);
        checkOutput("bypass_rs1", bus.ex_rs1_data_o, 32'hAA);
        s.wb_addr = 5'd0;
        applyStimulus(s);
        checkOutput("nobypass_rs1", bus.ex_rs1_data_o, 32'h11);

        // Load-use: lw x5,0(x1) then add x6,x5,x5.
        applyStimulus(mkStim(32'h0000_A283, 32'h300));
        applyStimulus(mkStim(32'h0052_8333, 32'h304));
`ifdef ID_LOAD_USE_INTERLOCK_EN
        checkOutput("lu_ready", last_ready, 0);
        checkOutput("lu_bubble", bus.ex_valid_o, 0);
        applyStimulus(mkStim(32'h0052_8333, 32'h304));
`else
        checkOutput("lu_ready", last_ready, 1);
`endif
        checkOutput("lu_add_valid", bus.ex_valid_o, 1);
        checkOutput("lu_add_rd", bus.ex_rd_addr_o, 6);
        held_pc = 32'h304;

        // Backpressure for three cycles, then a flush.
        for (int k = 0; k < 3; k++) begin
            s = mkStim(32'h0050_0093, 32'h400 + 4 * k);
            s.ex_ready = 1'b0;
            applyStimulus(s);
            checkOutput("stall_ready", last_ready, 0);
            checkOutput("stall_pc", bus.ex_pc_o, held_pc);
        end
        s = mkStim(32'h0050_0093, 32'h500);
        s.ex_ready = 1'b0; s.flush = 1'b1;
        applyStimulus(s);
        checkOutput("flush_ready", last_ready, 1);
        checkOutput("flush_valid", bus.ex_valid_o, 0);
        s = mkStim(32'h0, 32'h504);
        s.if_valid = 1'b0;
        applyStimulus(s);
        checkOutput("flush_dropped", bus.ex_valid_o, 0);

        // Branch immediate and illegal opcode.
        applyStimulus(mkStim(32'hFE00_0EE3, 32'h600));
        checkOutput("beq_imm", bus.ex_imm_o, 32'hFFFF_FFFC);
        checkOutput("beq_branch", bus.ex_branch_o, 1);
        checkOutput("beq_rd", bus.ex_rd_addr_o, 0);
        applyStimulus(mkStim(32'h0000_0FFF, 32'h604));
        checkOutput("ill_flag", bus.ex_illegal_o, 1);
        checkOutput("ill_regwrite", bus.ex_regwrite_o, 0);
        checkOutput("ill_valid", bus.ex_valid_o, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            s.rst_n    = ($urandom_range(0, 99) != 0);
            s.if_valid = ($urandom_range(0, 9) < 8);
            s.instr    = randInstr();
            s.pc       = $urandom & 32'hFFFF_FFFC;
            s.d1       = $urandom;
            s.d2       = $urandom;
            s.wb_en    = 1'($urandom_range(0, 1));
            s.wb_addr  = 5'($urandom_range(0, 7));
            s.wb_data  = $urandom;
            s.ex_ready = ($urandom_range(0, 3) != 0);
            s.flush    = ($urandom_range(0, 11) == 0);
            applyStimulus(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
